// File: rtl/mem_bist_pkg.sv
// Shared types and helpers for the memory BIST controller: FSM state encoding,
// expected-data rule and the read-latency legality limit.
package mem_bist_pkg;

  typedef enum logic [2:0] {
    IDLE,
    WR,
    RD,
    DRAIN,
    DONE
  } bist_state_e;

  localparam int RD_LAT_MAX = 1;

  // Pass 0 writes PATTERN ^ address, pass 1 writes the bitwise complement.
  function automatic logic [31:0] expectedData(input logic passIdx,
                                               input logic [31:0] addr,
                                               input logic [31:0] pattern);
    logic [31:0] base;
    base = pattern ^ addr;
    return passIdx ? ~base : base;
  endfunction

endpackage

// File: rtl/mem_bist_cmp.sv
// Read-back checker: delays expected data, address and valid by RD_LAT cycles to
// line up with the memory's read data, then counts mismatches and records the first.
module mem_bist_cmp
  import mem_bist_pkg::*;
#(
  parameter int ADDR_W = 2,
  parameter int DATA_W = 4,
  parameter int RD_LAT = 1,
  parameter int ERR_W  = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              clear_i,
  input  logic              valid_i,
  input  logic              cmpEn_i,
  input  logic [DATA_W-1:0] exp_i,
  input  logic [ADDR_W-1:0] addr_i,
  input  logic [DATA_W-1:0] rdata_i,
  output logic              mismatch_o,
  output logic [ERR_W-1:0]  errCount_o,
  output logic [ADDR_W-1:0] failAddr_o
);

  logic [DATA_W-1:0] dExp;
  logic [ADDR_W-1:0] dAddr;
  logic              dValid;

  logic [ERR_W-1:0]  err_q, err_d;
  logic [ADDR_W-1:0] fail_q, fail_d;

  generate
    if (RD_LAT == 0) begin : gNoDelay
      assign dExp   = exp_i;
      assign dAddr  = addr_i;
      assign dValid = valid_i;
    end else begin : gDelay
      logic [DATA_W-1:0] exp_q   [RD_LAT];
      logic [ADDR_W-1:0] addr_q  [RD_LAT];
      logic              valid_q [RD_LAT];

      always_ff @(posedge clk) begin
        if (rst || clear_i) begin
          for (int i = 0; i < RD_LAT; i++) begin
            exp_q[i]   <= '0;
            addr_q[i]  <= '0;
            valid_q[i] <= 1'b0;
          end
        end else begin
          exp_q[0]   <= exp_i;
          addr_q[0]  <= addr_i;
          valid_q[0] <= valid_i;
          for (int i = 1; i < RD_LAT; i++) begin
            exp_q[i]   <= exp_q[i-1];
            addr_q[i]  <= addr_q[i-1];
            valid_q[i] <= valid_q[i-1];
          end
        end
      end

      assign dExp   = exp_q[RD_LAT-1];
      assign dAddr  = addr_q[RD_LAT-1];
      assign dValid = valid_q[RD_LAT-1];
    end
  endgenerate

  // cmpEn_i masks stale delay-line entries once the sweep has been cut short.
  assign mismatch_o = cmpEn_i && dValid && (rdata_i != dExp);

  always_comb begin
    err_d  = err_q;
    fail_d = fail_q;
    if (clear_i) begin
      err_d  = '0;
      fail_d = '0;
    end else if (mismatch_o) begin
      if (err_q == '0) begin
        fail_d = dAddr;
      end
      if (err_q != '1) begin
        err_d = err_q + 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      err_q  <= '0;
      fail_q <= '0;
    end else begin
      err_q  <= err_d;
      fail_q <= fail_d;
    end
  end

  assign errCount_o = err_q;
  assign failAddr_o = fail_q;

endmodule

// File: rtl/mem_bist_ctrl.sv
// Two-pass write/read-back self-test controller for a single-port synchronous memory.
// Define MEM_BIST_STOP_ON_FAIL_EN to end the test at the first mismatch.
module mem_bist_ctrl
  import mem_bist_pkg::*;
#(
  parameter int                ADDR_W  = 2,
  parameter int                DATA_W  = 4,
  parameter int                RD_LAT  = 1,
  parameter logic [DATA_W-1:0] PATTERN = 4'b1010,
  parameter int                ERR_W   = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata,
  output logic              busy,
  output logic              done,
  output logic              pass,
  output logic [ERR_W-1:0]  err_count,
  output logic [ADDR_W-1:0] fail_addr
);

  localparam int DEPTH = 2 ** ADDR_W;
  localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(DEPTH - 1);

`ifdef MEM_BIST_STOP_ON_FAIL_EN
  localparam bit STOP_ON_FAIL = 1'b1;
`else
  localparam bit STOP_ON_FAIL = 1'b0;
`endif

  generate
    if (RD_LAT < 0 || RD_LAT > RD_LAT_MAX) begin : gBadRdLat
      $error("mem_bist_ctrl: RD_LAT must be 0 or 1");
    end
  endgenerate

  bist_state_e       state_q, state_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic              passIdx_q, passIdx_d;
  logic [DATA_W-1:0] wdata_q, wdata_d;
  logic              passRes_q, passRes_d;
  logic              clearRun;
  logic              mismatch;
  logic [DATA_W-1:0] expCur;
  logic [ERR_W-1:0]  errCount;
  logic [ADDR_W-1:0] failAddr;

  assign expCur = DATA_W'(expectedData(passIdx_q, 32'(addr_q), 32'(PATTERN)));

  mem_bist_cmp #(
    .ADDR_W(ADDR_W),
    .DATA_W(DATA_W),
    .RD_LAT(RD_LAT),
    .ERR_W (ERR_W)
  ) uCmp (
    .clk       (clk),
    .rst       (rst),
    .clear_i   (clearRun),
    .valid_i   (state_q == RD),
    .cmpEn_i   ((state_q == RD) || (state_q == DRAIN)),
    .exp_i     (expCur),
    .addr_i    (addr_q),
    .rdata_i   (mem_rdata),
    .mismatch_o(mismatch),
    .errCount_o(errCount),
    .failAddr_o(failAddr)
  );

  always_comb begin
    state_d   = state_q;
    addr_d    = addr_q;
    passIdx_d = passIdx_q;
    wdata_d   = wdata_q;
    passRes_d = passRes_q;
    clearRun  = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (start) begin
          state_d   = WR;
          addr_d    = '0;
          passIdx_d = 1'b0;
          passRes_d = 1'b0;
          clearRun  = 1'b1;
        end
      end
      WR: begin
        if (addr_q == LAST_ADDR) begin
          state_d = RD;
          addr_d  = '0;
        end else begin
          addr_d = addr_q + 1'b1;
        end
      end
      RD: begin
        if (addr_q != LAST_ADDR) begin
          addr_d = addr_q + 1'b1;
        end else if (RD_LAT != 0) begin
          state_d = DRAIN;
        end else if (!passIdx_q) begin
          state_d   = WR;
          passIdx_d = 1'b1;
          addr_d    = '0;
        end else begin
          state_d = DONE;
        end
      end
      DRAIN: begin
        if (!passIdx_q) begin
          state_d   = WR;
          passIdx_d = 1'b1;
          addr_d    = '0;
        end else begin
          state_d = DONE;
        end
      end
      DONE: begin
        state_d   = IDLE;
        passRes_d = (errCount == '0);
      end
      default: state_d = IDLE;
    endcase
    if (STOP_ON_FAIL && mismatch) begin
      state_d = DONE;
    end
    // Write data is registered alongside the address so both change on the same edge.
    if (state_d == WR) begin
      wdata_d = DATA_W'(expectedData(passIdx_d, 32'(addr_d), 32'(PATTERN)));
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= IDLE;
      addr_q    <= '0;
      passIdx_q <= 1'b0;
      wdata_q   <= '0;
      passRes_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      addr_q    <= addr_d;
      passIdx_q <= passIdx_d;
      wdata_q   <= wdata_d;
      passRes_q <= passRes_d;
    end
  end

  assign mem_we    = (state_q == WR);
  assign mem_addr  = addr_q;
  assign mem_wdata = wdata_q;
  assign busy      = (state_q == WR) || (state_q == RD) || (state_q == DRAIN);
  assign done      = (state_q == DONE);
  assign pass      = (state_q == DONE) ? (errCount == '0) : passRes_q;
  assign err_count = errCount;
  assign fail_addr = failAddr;

endmodule

// File: doc/mem_bist_ctrl.md
Name: mem_bist_ctrl

Overview:
- Initiator-side controller for the team's single-port synchronous memory.
- Drives we/addr/data_in into the memory and checks data_out.
- Runs a two-pass write/read-back self-test over every address on a start pulse, then reports pass/fail, error count and first failing address.
- Sits beside the memory instance; the memory's write/read ports are muxed to this block during test.

Parameters:
- ADDR_W, 2, memory address width; DEPTH = 2**ADDR_W.
- DATA_W, 4, memory data width.
- RD_LAT, 1, memory read latency in cycles from address to data_out; legal values 0 or 1.
- PATTERN, 4'b1010, base test pattern (DATA_W bits).
- ERR_W, 8, width of the saturating error counter.

Ports:
- clk  in  1  clock, all logic on rising edge.
- rst  in  1  synchronous reset, active-high.
- start  in  1  one-cycle request to begin a test; sampled only in IDLE.
- mem_we  out  1  memory write enable.
- mem_addr  out  ADDR_W  memory address.
- mem_wdata  out  DATA_W  memory write data.
- mem_rdata  in  DATA_W  memory read data.
- busy  out  1  high from the cycle after start is accepted until DONE.
- done  out  1  high for exactly one cycle at test end.
- pass  out  1  result; valid from done until next start.
- err_count  out  ERR_W  mismatches in this run, saturating at all-ones.
- fail_addr  out  ADDR_W  address of first mismatch; 0 if none.

Behaviour:
- Clock and reset: one clock; reset is synchronous and active-high (clk, rst).
- Reset values: all outputs 0, state IDLE. rst mid-run aborts on that edge and clears results, mem_we 0 thereafter; the memory contents are not restored.
- Expected data: pass 0 uses E0(a) = PATTERN ^ zero-extend(a); pass 1 uses E1(a) = ~E0(a).
- States: IDLE -> WR -> RD -> DRAIN -> (pass 0: WR with pass=1 | pass 1: DONE) -> IDLE.
- IDLE: mem_we 0. start=1 -> WR at address 0, pass index 0, err_count and fail_addr cleared, busy 1.
- WR: mem_we 1, mem_addr = addr counter, mem_wdata = E(pass, a). One address per cycle. At a = DEPTH-1 -> RD with a = 0.
- RD: mem_we 0, one address per cycle. The expected value, address and valid bit are delayed RD_LAT stages and compared with mem_rdata. At a = DEPTH-1 -> DRAIN.
- DRAIN: lasts RD_LAT cycles (skipped when RD_LAT=0) to retire the final compare.
- DONE: one cycle; done=1, busy=0, pass = (err_count==0) -> IDLE.
- Timing with defaults: state DONE is entered on the 18th edge after the start-sampling edge (2*(2*DEPTH+RD_LAT)).
- Mismatch: err_count increments (saturating). On the first mismatch of the run, fail_addr captures the delayed address.
- Address counter wraps modulo DEPTH; no out-of-range address is ever driven.
- start while busy is ignored. start and rst together: rst wins.
- mem_addr/mem_wdata hold their last value in IDLE; mem_we is never high outside WR.

Optional Feature:
- MEM_BIST_STOP_ON_FAIL_EN defined: the first mismatch ends the test. The controller goes directly to DONE on the next edge (remaining reads and pass are skipped), with err_count=1 and pass=0.
- Undefined: the full two-pass sweep always completes and every mismatch is counted.

Decomposition:
- Shared package mem_bist_pkg holds:
  - the state enum (IDLE, WR, RD, DRAIN, DONE);
  - the expected-data function E(pass, a, PATTERN);
  - the RD_LAT legality check constant.
- One natural sub-module: mem_bist_cmp, the RD_LAT-deep expected/address/valid delay line plus comparator and saturating error counter.

Test Plan:
- Fault-free 4x4 memory, RD_LAT=1, start pulse -> writes 1010,1011,1000,1001 then 0101,0100,0111,0110. done on the 18th edge after start; pass=1, err_count=0, fail_addr=0.
- Memory model with bit0 at address 2 stuck at 0 -> pass 1 reads 0110 vs expected 0111. done, pass=0, err_count=1, fail_addr=2.
- Every address returns 0000 (DATA_W=4) -> err_count=8, fail_addr=0, pass=0. With MEM_BIST_STOP_ON_FAIL_EN: err_count=1, fail_addr=0, done on the 6th edge after start.
- rst asserted in RD of pass 0 -> next cycle all outputs 0, mem_we 0, state IDLE. A new start runs a full clean test with pass=1.
- start re-pulsed while busy, and start held high across done -> the first is ignored with no restart. The held start launches a second run from IDLE with results cleared.
- RD_LAT=0 with a combinational-read memory -> DRAIN skipped, done on the 16th edge, pass=1.
